an_tx_tone_seq: RTL
===================

Name: an_tx_tone_seq

Overview:
- Tone sequencer/controller for the AN_TX audio datapath.
- Plays a small writable note table by feeding the DDS phase increment through a valid/ack handshake and muting between notes.
- Play/stop is toggled by the debounced board push switch; the table is loaded from the JTAG debug source bus.
- Sits in the top level between PSW/JTAG and AN_TX.

Parameters:
- C_CK_Fs, 135_000_000, clock frequency in Hz.
- C_TICK_HZ, 1000, duration tick rate (1 ms).
- C_PHASE_W, 32, DDS phase-increment width.
- C_DB_TICKS, 20, switch debounce length in ticks.
- C_GAP_TICKS, 2, muted gap between notes in ticks (0 allowed).

Ports:
- CK_i  in  1  system clock.
- XARST_i  in  1  reset; synchronous, active-low.
- XPSW_i  in  1  raw push switch, low = pressed, asynchronous.
- LOOP_i  in  1  1 = wrap to entry 0 at end marker.
- TBL_WE_i  in  1  table write strobe.
- TBL_ADR_i  in  3  table entry index (8 entries).
- TBL_INC_i  in  C_PHASE_W  phase increment to write.
- TBL_DUR_i  in  16  note duration in ticks; 0 = end marker.
- INC_o  out  C_PHASE_W  phase increment offered to AN_TX.
- INC_VLD_o  out  1  INC_o valid, held until ack.
- INC_ACK_i  in  1  datapath accepted INC_o (sample boundary).
- MUTE_o  out  1  1 = AN_TX output silenced.
- PLAYING_o  out  1  sequencer not idle.
- NOTE_IDX_o  out  3  current table index.
- PSW_PRESS_o  out  1  one-cycle debounced press pulse (debug).

Behaviour:
- Reset (XARST_i=0 at a CK_i edge):
  - Outputs: INC_o=0, INC_VLD_o=0, MUTE_o=1, PLAYING_o=0, NOTE_IDX_o=0, PSW_PRESS_o=0.
  - State=IDLE; prescalers and debounce cleared.
  - Table contents are not reset; all entries power up 0, i.e. end markers.
  - Reset mid-note: sequencer is in IDLE next cycle and any pending VLD is dropped.
- Tick prescaler: free-running counter 0..C_CK_Fs/C_TICK_HZ-1 (integer division); TICK is 1 cycle at wrap.
- Note timer: prescaler restarted on entry to PLAY/GAP, so a duration of D ticks is exactly D*(C_CK_Fs/C_TICK_HZ) cycles.
- Debounce:
  - XPSW_i passes through a 2-FF synchronizer.
  - A new level is accepted after it is stable for C_DB_TICKS consecutive TICKs; any change restarts the count.
  - Accepted high->low transition gives PSW_PRESS_o=1 for 1 cycle; release gives no pulse.
- Table: 8 x (C_PHASE_W+16) registers, written on TBL_WE_i in any state. A write takes effect when the entry is next loaded; the active note is unaffected.
- FSM:
  - IDLE: MUTE=1, PLAYING=0. On press -> LOAD with idx=0.
  - LOAD (1 cycle): read entry[idx].
    - DUR!=0: INC_o<=INC, INC_VLD_o<=1 -> REQ.
    - DUR==0 and LOOP_i=1 and idx!=0: idx<=0 -> LOAD.
    - Otherwise -> IDLE.
  - REQ: hold INC_o/INC_VLD_o stable while ACK=0. On ACK: VLD<=0, MUTE<=0, load duration -> PLAY. MUTE stays 1 until ACK.
  - PLAY: decrement on note tick; at 0, MUTE<=1.
    - C_GAP_TICKS>0 -> GAP.
    - C_GAP_TICKS=0 -> NEXT.
  - GAP: wait C_GAP_TICKS ticks -> NEXT.
  - NEXT (1 cycle): idx<=idx+1, wrapping 7->0. Wrap past 7 is allowed only if LOOP_i=1; else -> IDLE. Then -> LOAD.
- PLAYING_o=1 in every state except IDLE.
- Stop: a press in any non-IDLE state -> IDLE next cycle with MUTE=1, VLD=0, idx=0.
  - Press and ACK in the same cycle: stop wins and ACK is ignored.
- An ACK while VLD=0 is ignored.
- Latency: press pulse -> INC_VLD_o high = 2 cycles (IDLE->LOAD->REQ).

Test Plan:
- Sim parameters: C_CK_Fs=1000, C_TICK_HZ=100 (tick = 10 cycles), C_DB_TICKS=2, C_GAP_TICKS=1.
- Reset: drive XARST_i=0 mid-REQ -> next cycle VLD=0, MUTE=1, PLAYING=0, idx=0.
- Table {0:(0x1000,3), 1:(0x2000,2), 2:end}, LOOP_i=0, press -> INC_o=0x1000 with VLD until ACK; ACK after 5 cycles -> MUTE=0 for exactly 30 cycles, 10-cycle gap, then 0x2000 for 20 cycles, then IDLE with MUTE=1.
- Same table, LOOP_i=1 -> after entry 1 the sequencer returns to idx 0 and offers 0x1000 again. All-zero table with press -> IDLE after LOAD, VLD never asserted.
- Switch bounce: XPSW_i toggles every 3 cycles for 40 cycles, then steady low -> exactly one PSW_PRESS_o pulse, 20-29 cycles after it settles.
- Stop mid-PLAY via second press -> MUTE=1 and PLAYING=0 the cycle after the press pulse. Press coincident with ACK -> IDLE, MUTE stays 1.
- Write entry 0 (0x5555,1) while entry 0 is playing -> the current note is unchanged; the new value appears on the next loop pass.

Source files
------------

// File: rtl/an_tx_tone_seq.sv
// an_tx_tone_seq: tone sequencer feeding DDS phase increments to AN_TX.
// Plays an 8-entry note table, mutes between notes, toggled by push switch.
//
// Ports:
//   CK_i        system clock
//   XARST_i     synchronous active-low reset
//   XPSW_i      raw push switch (low = pressed, asynchronous)
//   LOOP_i      wrap to entry 0 at the end marker
//   TBL_*_i     note table write port (index, phase increment, duration)
//   INC_o       phase increment offered to AN_TX, with INC_VLD_o / INC_ACK_i
//   MUTE_o      AN_TX output silenced
//   PLAYING_o   sequencer not idle
//   NOTE_IDX_o  current table index
//   PSW_PRESS_o one-cycle debounced press pulse
module an_tx_tone_seq #(
    parameter int C_CK_Fs     = 135_000_000,
    parameter int C_TICK_HZ   = 1000,
    parameter int C_PHASE_W   = 32,
    parameter int C_DB_TICKS  = 20,
    parameter int C_GAP_TICKS = 2
) (
    input  logic                 CK_i,
    input  logic                 XARST_i,
    input  logic                 XPSW_i,
    input  logic                 LOOP_i,
    input  logic                 TBL_WE_i,
    input  logic [2:0]           TBL_ADR_i,
    input  logic [C_PHASE_W-1:0] TBL_INC_i,
    input  logic [15:0]          TBL_DUR_i,
    output logic [C_PHASE_W-1:0] INC_o,
    output logic                 INC_VLD_o,
    input  logic                 INC_ACK_i,
    output logic                 MUTE_o,
    output logic                 PLAYING_o,
    output logic [2:0]           NOTE_IDX_o,
    output logic                 PSW_PRESS_o
);

    localparam int LP_DIV = C_CK_Fs / C_TICK_HZ;
    localparam int LP_PW  = (LP_DIV > 1) ? $clog2(LP_DIV) : 1;
    localparam int LP_DBW = (C_DB_TICKS > 1) ? $clog2(C_DB_TICKS) : 1;
    localparam logic [LP_PW-1:0]  LP_PMAX  = LP_PW'(LP_DIV - 1);
    localparam logic [LP_DBW-1:0] LP_DBMAX = LP_DBW'(C_DB_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_PLAY,
        S_GAP,
        S_NEXT
    } state_t;

    // ---------------- note table (not reset) ----------------
    logic [C_PHASE_W-1:0] r_tbl_inc [8];
    logic [15:0]          r_tbl_dur [8];

    always_ff @(posedge CK_i) begin
        if (TBL_WE_i) begin
            r_tbl_inc[TBL_ADR_i] <= TBL_INC_i;
            r_tbl_dur[TBL_ADR_i] <= TBL_DUR_i;
        end
    end

    // ---------------- switch debounce ----------------
    logic              r_sync1;
    logic              r_sync2;
    logic              r_db_lvl;
    logic [LP_PW-1:0]  r_db_pre;
    logic [LP_DBW-1:0] r_db_cnt;
    logic              r_press;

    // The debounce tick restarts whenever the input returns to the
    // accepted level, so acceptance needs C_DB_TICKS full tick periods.
    always_ff @(posedge CK_i) begin
        if (!XARST_i) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_db_lvl <= 1'b1;
            r_db_pre <= '0;
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= XPSW_i;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_db_lvl) begin
                r_db_pre <= '0;
                r_db_cnt <= '0;
            end else if (r_db_pre == LP_PMAX) begin
                r_db_pre <= '0;
                if (r_db_cnt == LP_DBMAX) begin
                    r_db_lvl <= r_sync2;
                    r_db_cnt <= '0;
                    r_press  <= ~r_sync2;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_pre <= r_db_pre + 1'b1;
            end
        end
    end

    // ---------------- sequencer FSM ----------------
    state_t               r_state;
    state_t               w_nxt_state;
    logic [2:0]           r_idx;
    logic [2:0]           w_nxt_idx;
    logic [C_PHASE_W-1:0] r_inc;
    logic [C_PHASE_W-1:0] w_nxt_inc;
    logic [15:0]          r_cnt;
    logic [15:0]          w_nxt_cnt;
    logic [LP_PW-1:0]     r_npre;
    logic [LP_PW-1:0]     w_nxt_npre;
    logic                 w_ntick;
    logic [C_PHASE_W-1:0] w_ld_inc;
    logic [15:0]          w_ld_dur;

    assign w_ntick  = (r_npre == LP_PMAX);
    assign w_ld_inc = r_tbl_inc[r_idx];
    assign w_ld_dur = r_tbl_dur[r_idx];

    always_ff @(posedge CK_i) begin
        if (!XARST_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_inc   <= '0;
            r_cnt   <= '0;
            r_npre  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_inc   <= w_nxt_inc;
            r_cnt   <= w_nxt_cnt;
            r_npre  <= w_nxt_npre;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_inc   = r_inc;
        w_nxt_cnt   = r_cnt;
        w_nxt_npre  = w_ntick ? '0 : r_npre + 1'b1;
        // A press outside IDLE stops playback and wins over a same-cycle ACK.
        if (r_press && (r_state != S_IDLE)) begin
            w_nxt_state = S_IDLE;
            w_nxt_idx   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_press) begin
                        w_nxt_state = S_LOAD;
                        w_nxt_idx   = '0;
                    end
                end
                S_LOAD: begin
                    // Duration is latched here so later table writes
                    // cannot disturb the note being offered.
                    if (w_ld_dur != 16'd0) begin
                        w_nxt_inc   = w_ld_inc;
                        w_nxt_cnt   = w_ld_dur;
                        w_nxt_state = S_REQ;
                    end else if (LOOP_i && (r_idx != 3'd0)) begin
                        w_nxt_idx = '0;
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_nxt_idx   = '0;
                    end
                end
                S_REQ: begin
                    if (INC_ACK_i) begin
                        w_nxt_state = S_PLAY;
                        w_nxt_npre  = '0;
                    end
                end
                S_PLAY: begin
                    if (w_ntick) begin
                        if (r_cnt == 16'd1) begin
                            if (C_GAP_TICKS > 0) begin
                                w_nxt_state = S_GAP;
                                w_nxt_cnt   = 16'(C_GAP_TICKS);
                            end else begin
                                w_nxt_state = S_NEXT;
                            end
                        end else begin
                            w_nxt_cnt = r_cnt - 16'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (w_ntick) begin
                        if (r_cnt == 16'd1) begin
                            w_nxt_state = S_NEXT;
                        end else begin
                            w_nxt_cnt = r_cnt - 16'd1;
                        end
                    end
                end
                S_NEXT: begin
                    if ((r_idx == 3'd7) && !LOOP_i) begin
                        w_nxt_state = S_IDLE;
                        w_nxt_idx   = '0;
                    end else begin
                        w_nxt_state = S_LOAD;
                        w_nxt_idx   = r_idx + 3'd1;
                    end
                end
                default: begin
                    w_nxt_state = S_IDLE;
                    w_nxt_idx   = '0;
                end
            endcase
        end
    end

    assign INC_o       = r_inc;
    assign INC_VLD_o   = (r_state == S_REQ);
    assign MUTE_o      = (r_state != S_PLAY);
    assign PLAYING_o   = (r_state != S_IDLE);
    assign NOTE_IDX_o  = r_idx;
    assign PSW_PRESS_o = r_press;

endmodule
